// File: rtl/bp_sync_fifo_if.sv
// Handshake/status bundle for bp_sync_fifo: the producer/consumer side is the
// master, the FIFO itself is the slave.
interface bp_sync_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_shift;
  logic             write_en;
  logic [WIDTH-1:0] in_data;
  logic             in_full;
  logic             in_nempty;
  logic             out_pop;
  logic [WIDTH-1:0] out_data;
  logic             out_nempty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output in_shift, write_en, in_data, out_pop,
    input  in_full, in_nempty, out_data, out_nempty, level, overflow, underflow
  );

  modport slave (
    input  in_shift, write_en, in_data, out_pop,
    output in_full, in_nempty, out_data, out_nempty, level, overflow, underflow
  );
endinterface

// File: rtl/bp_sync_fifo.sv
// Single-clock FWFT FIFO with block-RAM storage, registered outputs and
// sticky overflow/underflow flags.
module bp_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512
) (
  input  logic          clock,
  input  logic          reset_n,
  bp_sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Assert asynchronously, release through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d, nempty_q, nempty_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_req, push_acc, pop_acc;

  assign push_req = bus.in_shift & bus.write_en;
  assign push_acc = push_req & ~full_q;
  assign pop_acc  = bus.out_pop & nempty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop_acc);
    level_d  = level_q + LW'(push_acc) - LW'(pop_acc);
    full_d   = (level_d == LW'(DEPTH));
    nempty_d = (level_d != '0);
    ovf_d    = ovf_q | (push_req & full_q);
    unf_d    = unf_q | (bus.out_pop & ~nempty_q);
    // Prefetch the next head; bypass the word being written when it lands on it.
    dout_d   = dout_q;
    if (nempty_d) begin
      if (push_acc && (wr_ptr_q == rd_ptr_d)) dout_d = bus.in_data;
      else                                    dout_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    if (push_acc) mem[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      nempty_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      nempty_q <= nempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.in_full    = full_q;
  assign bus.in_nempty  = nempty_q;
  assign bus.out_nempty = nempty_q;
  assign bus.out_data   = dout_q;
  assign bus.level      = level_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_bp_sync_fifo.sv
// Randomized bench for bp_sync_fifo against a queue-based FIFO model.
module tb_bp_sync_fifo;
  localparam int W  = 16;
  localparam int D  = 512;
  localparam int LW = 10;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bp_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
  bp_sync_fifo #(.WIDTH(W), .DEPTH(D)) u_dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_out;
  bit           exp_ovf, exp_unf;

  // Drive one cycle and advance the model; returns #1 after the edge.
  task automatic cycle(input bit sh, input bit we, input logic [W-1:0] d, input bit pp);
    bit full, empty, pu, po;
    bus.in_shift = sh; bus.write_en = we; bus.in_data = d; bus.out_pop = pp;
    full  = (q.size() == D);
    empty = (q.size() == 0);
    pu = sh && we && !full;
    po = pp && !empty;
    if (sh && we && full) exp_ovf = 1'b1;
    if (pp && empty)      exp_unf = 1'b1;
    @(posedge clock);
    if (po) void'(q.pop_front());
    if (pu) q.push_back(d);
    if (q.size() > 0) exp_out = q[0];
    #1;
    bus.in_shift = 1'b0; bus.write_en = 1'b0; bus.out_pop = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.in_shift = 1'b0; bus.write_en = 1'b0; bus.out_pop = 1'b0; bus.in_data = '0;
    q.delete(); exp_out = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_chk++; if (bus.level !== '0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", bus.level); end
    n_chk++; if ({bus.in_full, bus.in_nempty, bus.out_nempty, bus.overflow, bus.underflow} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000", {bus.in_full, bus.in_nempty, bus.out_nempty, bus.overflow, bus.underflow}); end
    n_chk++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0000", bus.out_data); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1, 1, 16'h1234, 0);
    n_chk++; if (bus.out_nempty !== 1'b1) begin n_fail++; $display("FAIL basic_nempty got %b exp 1", bus.out_nempty); end
    n_chk++; if (bus.out_data !== 16'h1234) begin n_fail++; $display("FAIL basic_fwft got %h exp 1234", bus.out_data); end
    n_chk++; if (bus.level !== LW'(1)) begin n_fail++; $display("FAIL basic_lvl1 got %0d exp 1", bus.level); end
    cycle(1, 1, 16'hABCD, 0);
    n_chk++; if (bus.level !== LW'(2)) begin n_fail++; $display("FAIL basic_lvl2 got %0d exp 2", bus.level); end
    cycle(0, 0, '0, 1);
    n_chk++; if (bus.out_data !== 16'hABCD) begin n_fail++; $display("FAIL basic_pop1 got %h exp abcd", bus.out_data); end
    cycle(0, 0, '0, 1);
    n_chk++; if ({bus.out_nempty, bus.in_nempty} !== 2'b00) begin n_fail++; $display("FAIL basic_empty got %b exp 00", {bus.out_nempty, bus.in_nempty}); end
    n_chk++; if (bus.level !== '0) begin n_fail++; $display("FAIL basic_lvl0 got %0d exp 0", bus.level); end
    n_chk++; if (bus.out_data !== 16'hABCD) begin n_fail++; $display("FAIL basic_hold got %h exp abcd", bus.out_data); end
    n_chk++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL basic_unf got %b exp 0", bus.underflow); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < D; i++) cycle(1, 1, W'(i), 0);
    cycle(1, 1, 16'hFFFF, 0);
    n_chk++; if (bus.in_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", bus.in_full); end
    n_chk++; if (bus.level !== LW'(D)) begin n_fail++; $display("FAIL fill_level got %0d exp %0d", bus.level, D); end
    n_chk++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %b exp 1", bus.overflow); end
    for (int i = 0; i < D; i++) begin
      n_chk++; if (bus.out_data !== W'(i) || bus.out_nempty !== 1'b1) begin
        n_fail++; $display("FAIL drain_data idx %0d got %h/%b exp %h/1", i, bus.out_data, bus.out_nempty, W'(i)); end
      cycle(0, 0, '0, 1);
    end
    n_chk++; if (bus.level !== '0 || bus.in_full !== 1'b0) begin n_fail++; $display("FAIL drain_end got lvl %0d full %b exp 0 0", bus.level, bus.in_full); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 300; i++) cycle(1, 1, W'($urandom), 0);
      n_chk++; if (bus.level !== LW'(300)) begin n_fail++; $display("FAIL wrap_level got %0d exp 300", bus.level); end
      for (int i = 0; i < 300; i++) begin
        n_chk++; if (bus.out_data !== exp_out) begin n_fail++; $display("FAIL wrap_data r%0d i%0d got %h exp %h", r, i, bus.out_data, exp_out); end
        cycle(0, 0, '0, 1);
      end
    end
    n_chk++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_fail++; $display("FAIL wrap_sticky got %b exp 00", {bus.overflow, bus.underflow}); end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, W'($urandom), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, W'($urandom), 1);
      n_chk++; if (bus.level !== LW'(5) || bus.out_data !== exp_out) begin
        n_fail++; $display("FAIL simul_mid got lvl %0d data %h exp 5 %h", bus.level, bus.out_data, exp_out); end
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus.out_data !== exp_out) begin n_fail++; $display("FAIL simul_drain got %h exp %h", bus.out_data, exp_out); end
      cycle(0, 0, '0, 1);
    end
    cycle(1, 1, 16'h5A5A, 1);
    n_chk++; if (bus.level !== LW'(1) || bus.out_data !== 16'h5A5A) begin n_fail++; $display("FAIL simul_empty got lvl %0d data %h exp 1 5a5a", bus.level, bus.out_data); end
    n_chk++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL simul_unf got u%b o%b exp u1 o0", bus.underflow, bus.overflow); end
    for (int i = 1; i < D; i++) cycle(1, 1, W'($urandom), 0);
    cycle(1, 1, 16'hDEAD, 1);
    n_chk++; if (bus.level !== LW'(D - 1) || bus.in_full !== 1'b0) begin n_fail++; $display("FAIL simul_full got lvl %0d full %b exp 511 0", bus.level, bus.in_full); end
    n_chk++; if (bus.overflow !== 1'b1 || bus.out_data !== exp_out) begin n_fail++; $display("FAIL simul_ovf got o%b data %h exp o1 %h", bus.overflow, bus.out_data, exp_out); end
  endtask

  task automatic test_write_en();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, W'(i + 7), 0);
    cycle(1, 0, 16'hBEEF, 0);
    n_chk++; if (bus.level !== LW'(3) || bus.out_data !== 16'h0007) begin n_fail++; $display("FAIL wen_gate got lvl %0d data %h exp 3 0007", bus.level, bus.out_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      int pw;
      pw = ((i / 250) % 2 == 0) ? 80 : 30;
      cycle($urandom_range(99) < pw, $urandom_range(9) != 0, W'($urandom), $urandom_range(99) < 50);
      n_chk++;
      if (bus.level !== LW'(q.size()) || bus.out_data !== exp_out || bus.out_nempty !== (q.size() != 0) ||
          bus.in_nempty !== (q.size() != 0) || bus.in_full !== (q.size() == D) ||
          bus.overflow !== exp_ovf || bus.underflow !== exp_unf) begin
        n_fail++;
        $display("FAIL random cyc %0d got lvl %0d data %h ne %b f %b o %b u %b exp lvl %0d data %h o %b u %b",
                 i, bus.level, bus.out_data, bus.out_nempty, bus.in_full, bus.overflow, bus.underflow,
                 q.size(), exp_out, exp_ovf, exp_unf);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 37; i++) cycle(1, 1, W'(i + 100), 0);
    n_chk++; if (bus.level !== LW'(37)) begin n_fail++; $display("FAIL mid_level got %0d exp 37", bus.level); end
    bus.in_shift = 1'b1; bus.write_en = 1'b1; bus.in_data = 16'h7777;
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (bus.level !== '0 || bus.out_data !== '0) begin n_fail++; $display("FAIL mid_async got lvl %0d data %h exp 0 0000", bus.level, bus.out_data); end
    n_chk++; if ({bus.in_full, bus.in_nempty, bus.out_nempty, bus.overflow, bus.underflow} !== 5'b0) begin
      n_fail++; $display("FAIL mid_flags got %b exp 00000", {bus.in_full, bus.in_nempty, bus.out_nempty, bus.overflow, bus.underflow}); end
    do_reset();
    cycle(0, 0, '0, 0);
    n_chk++; if (bus.level !== '0 || bus.out_nempty !== 1'b0) begin n_fail++; $display("FAIL mid_after got lvl %0d ne %b exp 0 0", bus.level, bus.out_nempty); end
  endtask

  initial begin
    bus.in_shift = 1'b0; bus.write_en = 1'b0; bus.in_data = '0; bus.out_pop = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simul();
    test_write_en();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_sync_fifo.md
Name: bp_sync_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO that buffers 16-bit words between the memory-controller register bank and the protocol engines (SPI master, PWM) of the Bus Pirate FPGA.
- The write side is driven by a "shift" strobe and the read side by a "pop" strobe.
- Status flags are fed back to the MCU-visible status register.
- Storage maps onto iCE40 block RAM.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 512, number of entries; must be a power of two, minimum 2.

Ports:
- clock      in   1              system clock; all logic on its rising edge.
- reset_n    in   1              asynchronous active-low reset.
- in_shift   in   1              push strobe; one word per cycle when high.
- write_en   in   1              push qualifier; a push happens only when in_shift=1 and write_en=1.
- in_data    in   WIDTH          word to push.
- in_full    out  1              FIFO holds DEPTH words.
- in_nempty  out  1              FIFO holds at least one word (write-side view).
- out_pop    in   1              pop strobe; removes the head word.
- out_data   out  WIDTH          head word (FWFT); valid while out_nempty=1.
- out_nempty out  1              head word available.
- level      out  log2(DEPTH)+1  current number of stored words.
- overflow   out  1              sticky; set when a push is attempted while in_full=1.
- underflow  out  1              sticky; set when a pop is attempted while out_nempty=0.

Behaviour:
- Reset, asserted asynchronously:
  - Read and write pointers = 0, level = 0.
  - in_full = 0, in_nempty = 0, out_nempty = 0.
  - out_data = 0, overflow = 0, underflow = 0.
- Release of reset is synchronized internally (2-flop) so the first active edge is clean.
- Reset asserted mid-operation discards all contents immediately; no partial words survive.
- Output registering:
  - All outputs are registered.
  - A push or pop sampled at edge k is reflected in level, all flags and out_data immediately after edge k.
  - No combinational path exists from any input to any output.
- Accepted push = in_shift & write_en & !in_full.
  - Stores in_data at the write pointer; the write pointer increments modulo DEPTH.
- Accepted pop = out_pop & out_nempty.
  - The read pointer increments modulo DEPTH; out_data shows the next word after the same edge.
- FWFT when empty: a push into an empty FIFO makes out_nempty=1 and out_data=in_data after that edge (bypass; zero added latency).
- Block RAM: the read-ahead (prefetch) register hides RAM read latency. Back-to-back pops every cycle must return consecutive words with no bubbles while level>0.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted; level unchanged.
  - Empty: the push is accepted, the pop is ignored and underflow is set.
  - Full: the pop is accepted, the push is ignored and overflow is set. A full FIFO does not accept a same-cycle replacement write.
- Rejected push: no state change except overflow=1. Rejected pop: no state change except underflow=1.
- out_data while empty holds the last popped value (0 after reset). Consumers must ignore it.
- Flags:
  - in_nempty = out_nempty = (level != 0); both are single-clock and identical.
  - in_full = (level == DEPTH).
- Pointer wrap: after DEPTH pushes and DEPTH pops, the pointers return to 0 seamlessly. Ordering is strictly first-in-first-out across the wrap.
- overflow and underflow clear only on reset.

Test Plan:
- Reset, then push 0x1234, 0xABCD (write_en=1) on consecutive cycles -> after the first edge out_nempty=1, out_data=0x1234, level=1. After the second edge level=2.
- Pop twice back-to-back -> out_data=0xABCD after the first pop. After the second pop out_nempty=0, level=0, out_data holds 0xABCD, underflow=0.
- Push 512 words 0..511, then push once more -> in_full=1, level=512, overflow=1. Pop all 512 -> values 0..511 in order, no bubbles.
- Push 300 words, pop 300, push 300, pop 300 (pointers wrap) -> data in order; underflow=0 and overflow=0 throughout.
- Simultaneous push+pop at level=5 -> level stays 5 and order is preserved. Push+pop at level 0 -> level=1, underflow=1. Push+pop at level=512 -> level=511, overflow=1.
- in_shift=1 with write_en=0 -> no push (level unchanged). Assert reset_n=0 mid-burst at level=37 -> all outputs return to reset values immediately, without waiting for a clock edge.
